id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of operand, immediate and PC fields.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, width of register-address fields.
REQ-003 Parameter CTRL_WIDTH, default 12, width of the packed decode-control bundle.
REQ-004 Parameter KILL_MASK, CTRL_WIDTH bits, default all-ones; set bits are forced to 0 whenever a bubble is formed.
REQ-005 Parameter CNT_WIDTH, default 16, width of the performance counters.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 stallE  input  1  hazard-unit request to hold the execute-stage contents.
REQ-009 flushE  input  1  hazard-unit request to kill the execute-stage contents.
REQ-010 validD  input  1  decode stage presents a real instruction.
REQ-011 readyD  output  1  stage can accept the decode payload this cycle.
REQ-012 ctrlD / ctrlE  input / output  CTRL_WIDTH  packed control bundle.
REQ-013 rd1D, rd2D, ImmExtD, pcD, PCPlus4D / matching *E  input / output  DATA_WIDTH each  operands, immediate, PC, PC+4.
REQ-014 Rs1D, Rs2D, RdD / matching *E  input / output  REG_ADDR_WIDTH each  source and destination register addresses.
REQ-015 funct3D / funct3E  input / output  3  instruction bits 14:12.
REQ-016 validE  output  1  execute stage holds a real instruction.
REQ-017 stall_cnt, bubble_cnt  output  CNT_WIDTH each  performance counters.

Function
REQ-018 Per rising edge, priority SHALL be: rst > flushE > hold > load.
REQ-019 Hold SHALL occur when stallE=1 and validE=1 and flushE=0: every E register keeps its value.
REQ-020 Load SHALL occur otherwise (no rst, no flushE, not hold): every E field takes its D counterpart; validE <= validD.
REQ-021 On load with validD=0, ctrlE SHALL take ctrlD & ~KILL_MASK.
REQ-022 On flush, validE SHALL become 0, ctrlE SHALL become ctrlE & ~KILL_MASK, and all data/address fields SHALL hold; the D payload is discarded.
REQ-023 flushE and stallE both high SHALL behave as flush.
REQ-024 stallE=1 with validE=0 SHALL load (bubble collapse): an empty stage never blocks decode.
REQ-025 readyD SHALL equal ~stallE | ~validE, combinational, independent of flushE and validD.
REQ-026 Load-to-output latency SHALL be exactly one cycle; no combinational path from any D payload input to any E output.
REQ-027 stall_cnt SHALL increment by 1 on every hold edge, saturating at 2^CNT_WIDTH-1.
REQ-028 bubble_cnt SHALL increment by 1 on every flush edge and every load edge with validD=0, saturating at 2^CNT_WIDTH-1.
REQ-029 Counters SHALL not wrap; at saturation further events are ignored.
REQ-030 All parameter values with DATA_WIDTH>=8, REG_ADDR_WIDTH>=1, CTRL_WIDTH>=1, CNT_WIDTH>=2 SHALL be supported.

Reset
REQ-031 On an edge with rst=1, validE, ctrlE, all data/address/funct3 outputs, stall_cnt and bubble_cnt SHALL become 0, regardless of stallE/flushE.
REQ-032 Reset asserted mid-stall SHALL take effect on that edge; after release readyD SHALL be 1 and the next edge SHALL load.
REQ-033 No output SHALL be X after the first reset edge.

Verification
REQ-034 Reset, then validD=1, ctrlD=12'hABC, rd1D=32'h1234_5678, RdD=5'd7 -> next cycle validE=1, ctrlE=12'hABC, rd1E=32'h1234_5678, RdE=7.
REQ-035 validE=1, stallE=1 for 3 edges with changing D inputs -> E outputs unchanged, readyD=0, stall_cnt=3.
REQ-036 validE=1, ctrlE=12'hFFF, KILL_MASK=12'h0F0, flushE=1 -> validE=0, ctrlE=12'hF0F, rd1E unchanged, bubble_cnt+1.
REQ-037 validE=0, stallE=1, validD=1 -> readyD=1, instruction loaded, validE=1, stall_cnt unchanged.
REQ-038 flushE=1 and stallE=1 together with validE=1 -> flush result, stall_cnt unchanged; CNT_WIDTH=2 with 5 stalls -> stall_cnt=3.
REQ-039 rst=1 during stall with nonzero counters -> all outputs and counters 0 next cycle, readyD=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold, flush, bubble insertion and
// saturating stall/bubble performance counters.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH     = 12,
    parameter logic [CTRL_WIDTH-1:0] KILL_MASK = '1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stallE,
    input  logic                      flushE,
    input  logic                      validD,
    output logic                      readyD,
    input  logic [CTRL_WIDTH-1:0]     ctrlD,
    input  logic [DATA_WIDTH-1:0]     rd1D,
    input  logic [DATA_WIDTH-1:0]     rd2D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     pcD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic [2:0]                funct3D,
    output logic                      validE,
    output logic [CTRL_WIDTH-1:0]     ctrlE,
    output logic [DATA_WIDTH-1:0]     rd1E,
    output logic [DATA_WIDTH-1:0]     rd2E,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     pcE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic [2:0]                funct3E,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      bubble_cnt
);

    logic                      valid_q,   valid_d;
    logic [CTRL_WIDTH-1:0]     ctrl_q,    ctrl_d;
    logic [DATA_WIDTH-1:0]     rd1_q,     rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q,     rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q,     imm_d;
    logic [DATA_WIDTH-1:0]     pc_q,      pc_d;
    logic [DATA_WIDTH-1:0]     pc4_q,     pc4_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,     rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,     rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,      rd_d;
    logic [2:0]                f3_q,      f3_d;
    logic [CNT_WIDTH-1:0]      stall_q,   stall_d;
    logic [CNT_WIDTH-1:0]      bubble_q,  bubble_d;

    logic hold;

    // An empty stage never holds, so a stall over a bubble lets decode advance.
    assign hold   = stallE & valid_q & ~flushE;
    assign readyD = ~stallE | ~valid_q;

    // Next-state selection: flush > hold > load (reset applied in the register block).
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        f3_d     = f3_q;
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (flushE) begin
            // Flush kills control only; data fields keep their old contents.
            valid_d = 1'b0;
            ctrl_d  = ctrl_q & ~KILL_MASK;
            if (bubble_q != '1) bubble_d = bubble_q + 1'b1;
        end else if (hold) begin
            if (stall_q != '1) stall_d = stall_q + 1'b1;
        end else begin
            valid_d = validD;
            ctrl_d  = validD ? ctrlD : (ctrlD & ~KILL_MASK);
            rd1_d   = rd1D;
            rd2_d   = rd2D;
            imm_d   = ImmExtD;
            pc_d    = pcD;
            pc4_d   = PCPlus4D;
            rs1_d   = Rs1D;
            rs2_d   = Rs2D;
            rd_d    = RdD;
            f3_d    = funct3D;
            if (!validD && bubble_q != '1) bubble_d = bubble_q + 1'b1;
        end
    end

    // Pipeline and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            pc4_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            f3_q     <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign validE     = valid_q;
    assign ctrlE      = ctrl_q;
    assign rd1E       = rd1_q;
    assign rd2E       = rd2_q;
    assign ImmExtE    = imm_q;
    assign pcE        = pc_q;
    assign PCPlus4E   = pc4_q;
    assign Rs1E       = rs1_q;
    assign Rs2E       = rs2_q;
    assign RdE        = rd_q;
    assign funct3E    = f3_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: one instance with a partial kill mask,
// one with 2-bit counters to exercise saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stallE, flushE, validD;
    logic [11:0] ctrlD;
    logic [31:0] rd1D, rd2D, ImmExtD, pcD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  funct3D;

    logic        readyD, validE;
    logic [11:0] ctrlE;
    logic [31:0] rd1E, rd2E, ImmExtE, pcE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [2:0]  funct3E;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        readyD_s, validE_s;
    logic [11:0] ctrlE_s;
    logic [31:0] rd1E_s, rd2E_s, ImmExtE_s, pcE_s, PCPlus4E_s;
    logic [4:0]  Rs1E_s, Rs2E_s, RdE_s;
    logic [2:0]  funct3E_s;
    logic [1:0]  stall_cnt_s, bubble_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CTRL_WIDTH(12),
                  .KILL_MASK(12'h0F0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .validD(validD),
        .readyD(readyD), .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .ImmExtD(ImmExtD),
        .pcD(pcD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .funct3D(funct3D), .validE(validE), .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E),
        .ImmExtE(ImmExtE), .pcE(pcE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .funct3E(funct3E), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .validD(validD),
        .readyD(readyD_s), .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .ImmExtD(ImmExtD),
        .pcD(pcD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .funct3D(funct3D), .validE(validE_s), .ctrlE(ctrlE_s), .rd1E(rd1E_s), .rd2E(rd2E_s),
        .ImmExtE(ImmExtE_s), .pcE(pcE_s), .PCPlus4E(PCPlus4E_s), .Rs1E(Rs1E_s), .Rs2E(Rs2E_s),
        .RdE(RdE_s), .funct3E(funct3E_s), .stall_cnt(stall_cnt_s), .bubble_cnt(bubble_cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] c, input logic [31:0] r1,
                         input logic [4:0] rd);
        validD   = v;
        ctrlD    = c;
        rd1D     = r1;
        rd2D     = ~r1;
        ImmExtD  = r1 ^ 32'h0F0F_0F0F;
        pcD      = r1 + 32'd8;
        PCPlus4D = r1 + 32'd12;
        Rs1D     = rd + 5'd1;
        Rs2D     = rd + 5'd2;
        RdD      = rd;
        funct3D  = rd[2:0];
    endtask

    initial begin
        // Reset with stall and flush also high
        rst = 1'b1; stallE = 1'b1; flushE = 1'b1;
        drive(1'b1, 12'h555, 32'hFFFF_FFFF, 5'd31);
        step();
        chk("rst_validE", validE, 0);
        chk("rst_ctrlE", ctrlE, 0);
        chk("rst_rd1E", rd1E, 0);
        chk("rst_pcE", pcE, 0);
        chk("rst_RdE", RdE, 0);
        chk("rst_funct3E", funct3E, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
        chk("rst_readyD", readyD, 1);

        // Basic load, one-cycle latency
        rst = 1'b0; stallE = 1'b0; flushE = 1'b0;
        drive(1'b1, 12'hABC, 32'h1234_5678, 5'd7);
        #1;
        chk("pre_load_validE", validE, 0);
        step();
        chk("load_validE", validE, 1);
        chk("load_ctrlE", ctrlE, 12'hABC);
        chk("load_rd1E", rd1E, 32'h1234_5678);
        chk("load_rd2E", rd2E, 32'hEDCB_A987);
        chk("load_ImmExtE", ImmExtE, 32'h1D3B_5977);
        chk("load_pcE", pcE, 32'h1234_5680);
        chk("load_PCPlus4E", PCPlus4E, 32'h1234_5684);
        chk("load_Rs1E", Rs1E, 8);
        chk("load_Rs2E", Rs2E, 9);
        chk("load_RdE", RdE, 7);
        chk("load_funct3E", funct3E, 7);
        chk("load_bubble_cnt", bubble_cnt, 0);

        // Hold for 3 edges with changing D inputs
        stallE = 1'b1;
        drive(1'b1, 12'h111, 32'h1111_1111, 5'd1);
        #1;
        chk("stall_readyD", readyD, 0);
        step();
        drive(1'b0, 12'h222, 32'h2222_2222, 5'd2);
        step();
        drive(1'b1, 12'h333, 32'h3333_3333, 5'd3);
        step();
        chk("hold_validE", validE, 1);
        chk("hold_ctrlE", ctrlE, 12'hABC);
        chk("hold_rd1E", rd1E, 32'h1234_5678);
        chk("hold_RdE", RdE, 7);
        chk("hold_pcE", pcE, 32'h1234_5680);
        chk("hold_readyD", readyD, 0);
        chk("hold_stall_cnt3", stall_cnt, 3);
        chk("hold_bubble_cnt", bubble_cnt, 0);
        chk("sat_stall_cnt3", stall_cnt_s, 3);
        step();
        step();
        chk("hold_stall_cnt5", stall_cnt, 5);
        chk("sat_stall_cnt5", stall_cnt_s, 3);

        // Load ctrl all-ones
        stallE = 1'b0;
        drive(1'b1, 12'hFFF, 32'hAAAA_5555, 5'd12);
        step();
        chk("load2_ctrlE", ctrlE, 12'hFFF);
        chk("load2_rd1E", rd1E, 32'hAAAA_5555);

        // Flush with stall also high: flush wins
        flushE = 1'b1; stallE = 1'b1;
        drive(1'b1, 12'h0A0, 32'hDEAD_BEEF, 5'd3);
        step();
        chk("flush_validE", validE, 0);
        chk("flush_ctrlE", ctrlE, 12'hF0F);
        chk("flush_rd1E", rd1E, 32'hAAAA_5555);
        chk("flush_RdE", RdE, 12);
        chk("flush_bubble_cnt", bubble_cnt, 1);
        chk("flush_stall_cnt", stall_cnt, 5);
        chk("flush_full_mask_ctrlE", ctrlE_s, 0);

        // Bubble collapse: stall over empty stage loads
        flushE = 1'b0; stallE = 1'b1;
        drive(1'b1, 12'h123, 32'h0BAD_F00D, 5'd9);
        #1;
        chk("collapse_readyD", readyD, 1);
        step();
        chk("collapse_validE", validE, 1);
        chk("collapse_ctrlE", ctrlE, 12'h123);
        chk("collapse_rd1E", rd1E, 32'h0BAD_F00D);
        chk("collapse_stall_cnt", stall_cnt, 5);

        // Load of an invalid slot masks control and counts a bubble
        stallE = 1'b0;
        drive(1'b0, 12'hFFF, 32'h0000_0042, 5'd4);
        step();
        chk("bubble_validE", validE, 0);
        chk("bubble_ctrlE", ctrlE, 12'hF0F);
        chk("bubble_rd1E", rd1E, 32'h0000_0042);
        chk("bubble_bubble_cnt", bubble_cnt, 2);
        chk("bubble_sat_ctrlE", ctrlE_s, 0);

        // Valid load then one stall
        drive(1'b1, 12'h456, 32'h7777_0000, 5'd5);
        step();
        stallE = 1'b1;
        step();
        chk("stall6_stall_cnt", stall_cnt, 6);
        chk("stall6_readyD", readyD, 0);

        // Reset mid-stall
        rst = 1'b1;
        step();
        chk("rst2_validE", validE, 0);
        chk("rst2_ctrlE", ctrlE, 0);
        chk("rst2_rd1E", rd1E, 0);
        chk("rst2_stall_cnt", stall_cnt, 0);
        chk("rst2_bubble_cnt", bubble_cnt, 0);
        chk("rst2_sat_stall_cnt", stall_cnt_s, 0);
        chk("rst2_readyD", readyD, 1);

        // After release the next edge loads even with stall held
        rst = 1'b0;
        drive(1'b1, 12'h789, 32'hCAFE_0001, 5'd17);
        step();
        chk("post_rst_validE", validE, 1);
        chk("post_rst_ctrlE", ctrlE, 12'h789);
        chk("post_rst_RdE", RdE, 17);

        // Bubble counter saturation: four flushes
        flushE = 1'b1; stallE = 1'b0;
        step(); step(); step(); step();
        chk("flush4_bubble_cnt", bubble_cnt, 4);
        chk("flush4_sat_bubble_cnt", bubble_cnt_s, 3);
        chk("flush4_rd1E", rd1E, 32'hCAFE_0001);
        flushE = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
